// File: rtl/dom_shared_mul_gf2n.sv
// Domain-oriented masked GF(2^N) multiplier with SHARES shares.
// One register stage of inner and remasked cross terms, optional output register.
module dom_shared_mul_gf2n #(
  parameter int N      = 2,
  parameter int SHARES = 2,
  parameter int OUTREG = 0
) (
  input  logic                              ClkxCI,
  input  logic                              RstxBI,
  input  logic                              ValidxSI,
  input  logic [N*SHARES-1:0]               XxDI,
  input  logic [N*SHARES-1:0]               YxDI,
  input  logic [N*SHARES*(SHARES-1)/2-1:0]  ZxDI,
  output logic                              ValidxSO,
  output logic [N*SHARES-1:0]               QxDO
);

  localparam int L = 1 + OUTREG;
  // x^2+x+1 and x^4+x+1 both reduce x^N to x+1
  localparam logic [N-1:0] RED_POLY = N'(3);

  if (N != 2 && N != 4) begin : g_bad_n
    $error("dom_shared_mul_gf2n: N must be 2 or 4");
  end
  if (SHARES < 2 || SHARES > 4) begin : g_bad_shares
    $error("dom_shared_mul_gf2n: SHARES must be in 2..4");
  end
  if (OUTREG != 0 && OUTREG != 1) begin : g_bad_outreg
    $error("dom_shared_mul_gf2n: OUTREG must be 0 or 1");
  end

  function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] acc;
    logic [N-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < N; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[N-1] ? ((sh << 1) ^ RED_POLY) : (sh << 1);
    end
    return acc;
  endfunction

  function automatic int pair_idx(input int i, input int j);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * SHARES - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  logic [N-1:0] term_d [SHARES][SHARES];
  logic [N-1:0] term_q [SHARES][SHARES];
  logic [L-1:0] valid_d, valid_q;
  logic [N*SHARES-1:0] q_comb;

  // Cross terms are remasked here and must reach a register before any XOR tree
  always_comb begin
    for (int i = 0; i < SHARES; i++) begin
      for (int j = 0; j < SHARES; j++) begin
        term_d[i][j] = term_q[i][j];
      end
    end
    if (ValidxSI) begin
      for (int i = 0; i < SHARES; i++) begin
        for (int j = 0; j < SHARES; j++) begin
          if (i == j) begin
            term_d[i][j] = gf_mul(XxDI[i*N +: N], YxDI[i*N +: N]);
          end else begin
            term_d[i][j] = gf_mul(XxDI[i*N +: N], YxDI[j*N +: N]) ^ ZxDI[pair_idx(i, j)*N +: N];
          end
        end
      end
    end
  end

  always_comb begin
    valid_d    = valid_q;
    valid_d[0] = ValidxSI;
    for (int i = 1; i < L; i++) begin
      valid_d[i] = valid_q[i-1];
    end
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      valid_q <= '0;
      for (int i = 0; i < SHARES; i++) begin
        for (int j = 0; j < SHARES; j++) begin
          term_q[i][j] <= '0;
        end
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < SHARES; i++) begin
        for (int j = 0; j < SHARES; j++) begin
          term_q[i][j] <= term_d[i][j];
        end
      end
    end
  end

  always_comb begin
    q_comb = '0;
    for (int i = 0; i < SHARES; i++) begin
      q_comb[i*N +: N] = term_q[i][i];
      for (int j = 0; j < SHARES; j++) begin
        if (j != i) q_comb[i*N +: N] = q_comb[i*N +: N] ^ term_q[i][j];
      end
    end
  end

  if (OUTREG == 1) begin : g_outreg
    logic [N*SHARES-1:0] q_d, q_q;

    always_comb q_d = valid_q[0] ? q_comb : q_q;

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) q_q <= '0;
      else         q_q <= q_d;
    end

    assign QxDO = q_q;
  end else begin : g_comb
    assign QxDO = q_comb;
  end

  assign ValidxSO = valid_q[L-1];

endmodule

// File: doc/dom_shared_mul_gf2n.md
DOM_SHARED_MUL_GF2N -- requirements
Module: dom_shared_mul_gf2n

Interface
REQ-001 The module SHALL have parameter N, default 2, meaning field width (legal values 2 and 4).
REQ-002 The module SHALL have parameter SHARES, default 2, meaning masking share count (legal values 2..4, so protection order is SHARES-1).
REQ-003 The module SHALL have parameter OUTREG, default 0, meaning one extra output register stage (legal values 0 and 1).
REQ-004 ClkxCI  input  1  clock; all registers update on the rising edge.
REQ-005 RstxBI  input  1  reset; asynchronous, active-low.
REQ-006 ValidxSI  input  1  the sharing on X/Y/Z is valid this cycle.
REQ-007 _XxDI  input  N*SHARES  X shares; share i occupies bits [i*N+N-1 : i*N].
REQ-008 _YxDI  input  N*SHARES  Y shares; same packing as _XxDI.
REQ-009 _ZxDI  input  N*SHARES*(SHARES-1)/2  fresh randomness; word k is assigned to pair (i,j), i<j, with k in lexicographic order: (0,1)=0, (0,2)=1, ...
REQ-010 ValidxSO  output  1  _QxDO holds a valid result sharing this cycle.
REQ-011 _QxDO  output  N*SHARES  Q shares; same packing as _XxDI.

Function
REQ-012 All multiplications SHALL be in GF(2^N), polynomial basis: reduction polynomial x^2+x+1 for N=2 and x^4+x+1 for N=4; bit 0 is the constant coefficient.
REQ-013 Out-of-range N or SHARES SHALL stop elaboration with an error.
REQ-014 Stage 1, when ValidxSI=1, SHALL register inner terms P_ii = x_i*y_i and remasked cross terms C_ij = x_i*y_j XOR z_k for every i≠j; C_ij and C_ji both use z_k for pair (min(i,j), max(i,j)).
REQ-015 When ValidxSI=0, stage-1 registers SHALL hold their previous values (no toggling on bubbles).
REQ-016 Cross-domain terms SHALL NOT be combined with any other term before they are registered.
REQ-017 Q_i SHALL equal P_ii XOR (XOR over j≠i of C_ij), computed from stage-1 registers only.
REQ-018 With OUTREG=1, Q SHALL pass through a second register enabled by the stage-1 valid flag; with OUTREG=0, Q SHALL be combinational from stage-1 registers.
REQ-019 Latency SHALL be L = 1+OUTREG cycles: ValidxSO SHALL be ValidxSI delayed by L cycles through an L-deep valid shift register.
REQ-020 Throughput SHALL be one sharing per cycle; back-to-back valids SHALL produce back-to-back outputs in order.
REQ-021 Bubbles in ValidxSI SHALL reproduce as identical bubbles in ValidxSO, and _QxDO SHALL hold its last valid value during bubbles.
REQ-022 Correctness: XOR of all Q_i SHALL equal (XOR of all x_i)*(XOR of all y_i) for every valid transaction, independent of Z.
REQ-023 Inputs SHALL only need to be stable in the cycle where ValidxSI=1; no multi-cycle hold is required.
REQ-024 Z SHALL be sampled only in ValidxSI cycles; each pair word is consumed exactly once per transaction.

Reset
REQ-025 While RstxBI=0, all data registers SHALL be 0, all valid-pipeline bits SHALL be 0, ValidxSO SHALL be 0 and _QxDO SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL discard every in-flight transaction; no ValidxSO pulse SHALL appear for them after release.
REQ-027 The first rising edge after RstxBI deasserts SHALL be a normal operating edge; a ValidxSI on that edge SHALL produce ValidxSO L cycles later.

Verification
REQ-028 N=2, SHARES=2, OUTREG=0, X=(1,3), Y=(2,0), Z=1, ValidxSI pulse -> next cycle ValidxSO=1, Q0=3, Q1=0, XOR=3 (=2*2).
REQ-029 N=4, SHARES=3, OUTREG=1, x=0x2 and y=0x8 split with random shares and random Z -> ValidxSO exactly 2 cycles later, XOR of Q = 0x3.
REQ-030 Exhaustive check, N=2, SHARES=2..4: all x and y, random shares and Z, back-to-back valids -> every output unshares to x*y, in order, one per cycle.
REQ-031 Valid pattern 1,0,0,1,1,0 -> ValidxSO shows the same pattern shifted by L, and Q stays unchanged across the 0 cycles.
REQ-032 Reset pulsed one cycle after a valid, with OUTREG=1 -> ValidxSO and Q stay 0; no stale output appears after release.
REQ-033 Same x, y with two different Z draws -> the individual Q_i differ but the unshared result is identical.
